// File: rtl/control_unit.sv
// K&S processor control FSM: fetch, decode, one execute cycle.
// Define KS_BOV_SIGNED_EN to make I_BOV/I_BNOV test signed_overflow.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_LOAD   = 3'd2,
    S_STORE  = 3'd3,
    S_ALU    = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_ovf;
  logic   w_unused;

`ifdef KS_BOV_SIGNED_EN
  assign w_ovf    = signed_overflow;
  assign w_unused = unsigned_overflow;
`else
  assign w_ovf    = unsigned_overflow;
  assign w_unused = signed_overflow;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next           = S_FETCH;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        addr_sel  = 1'b1;
        ir_enable = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        pc_enable = 1'b1;
        case (decoded_instruction)
          I_LOAD:   w_next = S_LOAD;
          I_STORE:  w_next = S_STORE;
          I_MOVE,
          I_ADD,
          I_SUB,
          I_AND,
          I_OR:     w_next = S_ALU;
          I_BRANCH: w_next = S_BRANCH;
          I_BZERO:  w_next = zero_op  ? S_BRANCH : S_FETCH;
          I_BNZERO: w_next = !zero_op ? S_BRANCH : S_FETCH;
          I_BNEG:   w_next = neg_op   ? S_BRANCH : S_FETCH;
          I_BNNEG:  w_next = !neg_op  ? S_BRANCH : S_FETCH;
          I_BOV:    w_next = w_ovf    ? S_BRANCH : S_FETCH;
          I_BNOV:   w_next = !w_ovf   ? S_BRANCH : S_FETCH;
          I_HALT:   w_next = S_HALT;
          default:  w_next = S_FETCH;
        endcase
      end
      S_LOAD: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_STORE: begin
        ram_write_enable = 1'b1;
      end
      S_ALU: begin
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        case (decoded_instruction)
          I_AND:   operation = 2'b01;
          I_OR:    operation = 2'b10;
          I_SUB:   operation = 2'b11;
          // MOVE is a|a and must not disturb the flags
          I_MOVE: begin
            operation        = 2'b10;
            flags_reg_enable = 1'b0;
          end
          default: operation = 2'b00;
        endcase
      end
      S_BRANCH: begin
        pc_enable = 1'b1;
        branch    = 1'b1;
      end
      S_HALT: begin
        halt   = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
    if (!rst_n) begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = 2'b00;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit.
// Honours KS_BOV_SIGNED_EN when choosing expected branch outcomes.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  decoded_instruction_type instr;
  logic zero_op, neg_op, uov, sov;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic wre, fre, rwe, halt;
  logic [10:0] outs;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .decoded_instruction (instr),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (uov),
    .signed_overflow     (sov),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (wre),
    .flags_reg_enable    (fre),
    .ram_write_enable    (rwe),
    .halt                (halt)
  );

  // {branch,pc,ir,addr_sel,c_sel,op[1:0],wre,fre,rwe,halt}
  assign outs = {branch, pc_enable, ir_enable, addr_sel, c_sel,
                 operation, wre, fre, rwe, halt};

  localparam logic [10:0] O_ZERO   = 11'h000;
  localparam logic [10:0] O_FETCH  = 11'h180;
  localparam logic [10:0] O_DECODE = 11'h200;
  localparam logic [10:0] O_LOAD   = 11'h048;
  localparam logic [10:0] O_STORE  = 11'h002;
  localparam logic [10:0] O_ADD    = 11'h00C;
  localparam logic [10:0] O_AND    = 11'h01C;
  localparam logic [10:0] O_OR     = 11'h02C;
  localparam logic [10:0] O_SUB    = 11'h03C;
  localparam logic [10:0] O_MOVE   = 11'h028;
  localparam logic [10:0] O_BRANCH = 11'h600;
  localparam logic [10:0] O_HALT   = 11'h001;

  typedef struct {
    string                   name;
    decoded_instruction_type ins;
    logic                    z, n, uo, so;
    logic                    exec;
    logic [10:0]             exp;
  } vec_t;

  vec_t vec[18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [10:0] exp);
    tests++;
    if (outs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, outs, exp);
    end
  endtask

  task automatic setv(input int i, input string nm,
                      input decoded_instruction_type ins,
                      input logic z, input logic n,
                      input logic uo, input logic so,
                      input logic ex, input logic [10:0] exp);
    vec[i].name = nm;
    vec[i].ins  = ins;
    vec[i].z    = z;
    vec[i].n    = n;
    vec[i].uo   = uo;
    vec[i].so   = so;
    vec[i].exec = ex;
    vec[i].exp  = ex ? exp : O_FETCH;
  endtask

  initial begin
    logic bov_sig;
`ifdef KS_BOV_SIGNED_EN
    bov_sig = 1'b1;
`else
    bov_sig = 1'b0;
`endif
    setv(0,  "add",      I_ADD,    0, 0, 0, 0, 1, O_ADD);
    setv(1,  "move",     I_MOVE,   0, 0, 0, 0, 1, O_MOVE);
    setv(2,  "and",      I_AND,    1, 1, 1, 1, 1, O_AND);
    setv(3,  "or",       I_OR,     0, 0, 0, 0, 1, O_OR);
    setv(4,  "sub",      I_SUB,    0, 0, 0, 0, 1, O_SUB);
    setv(5,  "load",     I_LOAD,   0, 0, 0, 0, 1, O_LOAD);
    setv(6,  "store",    I_STORE,  0, 0, 0, 0, 1, O_STORE);
    setv(7,  "branch",   I_BRANCH, 0, 0, 0, 0, 1, O_BRANCH);
    setv(8,  "bzero_t",  I_BZERO,  1, 0, 0, 0, 1, O_BRANCH);
    setv(9,  "bzero_n",  I_BZERO,  0, 1, 1, 1, 0, O_FETCH);
    setv(10, "bnzero_t", I_BNZERO, 0, 0, 0, 0, 1, O_BRANCH);
    setv(11, "bnzero_n", I_BNZERO, 1, 0, 0, 0, 0, O_FETCH);
    setv(12, "bneg_t",   I_BNEG,   0, 1, 0, 0, 1, O_BRANCH);
    setv(13, "bnneg_n",  I_BNNEG,  0, 1, 0, 0, 0, O_FETCH);
    setv(14, "bov_u",    I_BOV,    0, 0, 1, 0, !bov_sig, O_BRANCH);
    setv(15, "bnov_u",   I_BNOV,   0, 0, 1, 0, bov_sig, O_BRANCH);
    setv(16, "bnov_s",   I_BNOV,   0, 0, 0, 1, !bov_sig, O_BRANCH);
    setv(17, "nop",      I_NOP,    1, 1, 1, 1, 0, O_FETCH);

    rst_n = 1'b0;
    instr = I_NOP;
    {zero_op, neg_op, uov, sov} = 4'b0;
    #1;
    chk("rst_comb", O_ZERO);
    step();
    chk("rst_c1", O_ZERO);
    step();
    chk("rst_c2", O_ZERO);
    rst_n = 1'b1;
    #1;
    chk("rel_fetch", O_FETCH);
    step();
    chk("rel_decode", O_DECODE);
    step();
    chk("rel_fetch2", O_FETCH);

    for (int i = 0; i < 18; i++) begin
      chk({vec[i].name, "_fetch"}, O_FETCH);
      instr   = vec[i].ins;
      zero_op = vec[i].z;
      neg_op  = vec[i].n;
      uov     = vec[i].uo;
      sov     = vec[i].so;
      step();
      chk({vec[i].name, "_decode"}, O_DECODE);
      step();
      chk({vec[i].name, "_exec"}, vec[i].exp);
      if (vec[i].exec) step();
    end

    // reset in the middle of a STORE kills the write strobe
    chk("st_fetch", O_FETCH);
    instr = I_STORE;
    step();
    chk("st_decode", O_DECODE);
    step();
    chk("st_exec", O_STORE);
    rst_n = 1'b0;
    #1;
    chk("st_abort", O_ZERO);
    step();
    chk("st_rst", O_ZERO);
    rst_n = 1'b1;
    #1;
    chk("st_refetch", O_FETCH);

    // HALT is absorbing until reset
    instr = I_HALT;
    step();
    chk("h_decode", O_DECODE);
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("h_hold%0d", c), O_HALT);
    end
    rst_n = 1'b0;
    #1;
    chk("h_rst_comb", O_ZERO);
    step();
    chk("h_rst", O_ZERO);
    rst_n = 1'b1;
    instr = I_NOP;
    #1;
    chk("h_refetch", O_FETCH);
    step();
    chk("h_redecode", O_DECODE);
    step();
    chk("h_nop_fetch", O_FETCH);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
